// File: rtl/timer_dev.sv
// Memory-mapped countdown timer behind the CPU bridge: CTRL/PRESET/COUNT registers plus a maskable interrupt.
// Optional macro TIMER_COUNT_WR_EN makes COUNT (addr 2) writable; without it, writes to addr 2 are ignored.
module timer_dev #(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  PRESET_RST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              irq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state_reg;
  logic [3:0]        ctrl_reg;
  logic [DATA_W-1:0] preset_reg;
  logic [DATA_W-1:0] count_reg;
  logic              irq_flag_reg;

  logic       en;
  logic [1:0] mode;
  logic       im;

  assign en   = ctrl_reg[0];
  assign mode = ctrl_reg[2:1];
  assign im   = ctrl_reg[3];

  // FSM and bus writes share one block; bus writes come last so they win any same-edge collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      ctrl_reg     <= 4'd0;
      preset_reg   <= PRESET_RST;
      count_reg    <= '0;
      irq_flag_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (en) begin
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count_reg <= preset_reg;
          state_reg <= ST_CNT;
        end
        ST_CNT: begin
          if (!en) begin
            state_reg <= ST_IDLE;
          end else if (count_reg <= ONE) begin
            // Also catches a zero preset, so the count never wraps.
            count_reg    <= '0;
            irq_flag_reg <= 1'b1;
            state_reg    <= ST_INT;
          end else begin
            count_reg <= count_reg - ONE;
          end
        end
        ST_INT: begin
          if (mode == 2'b01) begin
            irq_flag_reg <= 1'b0;
            state_reg    <= ST_LOAD;
          end else begin
            ctrl_reg[0] <= 1'b0;
            state_reg   <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase

      if (we) begin
        case (addr)
          2'd0: begin
            ctrl_reg     <= din[3:0];
            irq_flag_reg <= 1'b0;
          end
          2'd1: begin
            preset_reg <= din;
          end
`ifdef TIMER_COUNT_WR_EN
          2'd2: begin
            count_reg <= din;
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      2'd0:    dout = {{(DATA_W-4){1'b0}}, ctrl_reg};
      2'd1:    dout = preset_reg;
      2'd2:    dout = count_reg;
      default: dout = '0;
    endcase
  end

  assign irq = irq_flag_reg & im;

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: each stimulus cycle may queue an expected {dout, irq};
// a negedge monitor pops and compares while the check strobe is up.
module tb_timer_dev;

  localparam int          DW = 32;
  localparam logic [31:0] PR = 32'h0000_1234;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        we    = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic [31:0] din   = 32'd0;
  logic [31:0] dout;
  logic        irq;

  timer_dev #(.DATA_W(DW), .PRESET_RST(PR)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_dout_q[$];
  logic        exp_irq_q[$];
  string       name_q[$];
  logic        chk = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Monitor: compares the registered-state view presented between edges.
  always @(negedge clk) begin
    logic [31:0] ed;
    logic        ei;
    string       nm;
    if (chk) begin
      if (exp_dout_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow at %0t", $time);
      end else begin
        ed = exp_dout_q.pop_front();
        ei = exp_irq_q.pop_front();
        nm = name_q.pop_front();
        n_checks += 2;
        if (dout !== ed || irq !== ei) begin
          if (dout !== ed) n_fail++;
          if (irq !== ei) n_fail++;
          $display("FAIL %s addr=%0d: dout got %0h expected %0h, irq got %0b expected %0b",
                   nm, addr, dout, ed, irq, ei);
        end else begin
          $display("pass %s addr=%0d dout=%0h irq=%0b", nm, addr, dout, irq);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d,
                      input bit c, input logic [31:0] ed, input logic ei, input string nm);
    we   = w;
    addr = a;
    din  = d;
    chk  = c;
    if (c) begin
      exp_dout_q.push_back(ed);
      exp_irq_q.push_back(ei);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, a, d, 1'b0, 32'd0, 1'b0, "");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] ed, input logic ei, input string nm);
    step(1'b0, a, 32'd0, 1'b1, ed, ei, nm);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b0, "");
  endtask

  logic [31:0] os_cnt [5] = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
  logic [31:0] ar_cnt [5] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
  logic        ar_irq [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    @(posedge clk);
    #1;
    idle();
    idle();
    reset = 1'b0;
    rd(2'd0, 32'd0, 1'b0, "rst_ctrl");
    rd(2'd1, PR,    1'b0, "rst_preset");
    rd(2'd2, 32'd0, 1'b0, "rst_count");
    rd(2'd3, 32'd0, 1'b0, "rst_addr3");

    // One-shot, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    rd(2'd0, 32'h9, 1'b0, "os_ctrl");
    rd(2'd2, 32'd0, 1'b0, "os_load");
    for (int i = 0; i < 5; i++) rd(2'd2, os_cnt[i], 1'b0, "os_count");
    rd(2'd2, 32'd0, 1'b1, "os_int");
    rd(2'd0, 32'h8, 1'b1, "os_ctrl_en_cleared");
    rd(2'd2, 32'd0, 1'b1, "os_irq_held");
    step(1'b1, 2'd0, 32'd0, 1'b1, 32'h8, 1'b1, "os_clear_write");
    rd(2'd0, 32'd0, 1'b0, "os_irq_cleared");

    // Auto-reload, PRESET=3: period 5
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    rd(2'd2, 32'd0, 1'b0, "ar_idle");
    for (int k = 1; k <= 20; k++) rd(2'd2, ar_cnt[(k-1)%5], ar_irq[(k-1)%5], "ar_period");
    rd(2'd2, 32'd0, 1'b0, "ar_load");
    step(1'b1, 2'd1, 32'd9, 1'b1, 32'd3, 1'b0, "ar_preset_write");
    rd(2'd2, 32'd2, 1'b0, "ar_old_run");
    rd(2'd2, 32'd1, 1'b0, "ar_old_run");
    rd(2'd2, 32'd0, 1'b1, "ar_old_int");
    rd(2'd2, 32'd0, 1'b0, "ar_reload");
    rd(2'd2, 32'd9, 1'b0, "ar_new_preset");
    rd(2'd2, 32'd8, 1'b0, "ar_new_run");

    // Reset mid-count
    reset = 1'b1;
    rd(2'd2, 32'd7, 1'b0, "mid_reset_count");
    reset = 1'b0;
    rd(2'd0, 32'd0, 1'b0, "mid_reset_ctrl");
    rd(2'd1, PR,    1'b0, "mid_reset_preset");
    rd(2'd2, 32'd0, 1'b0, "mid_reset_count_after");

    // Masked interrupt, PRESET=2
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    rd(2'd2, 32'd0, 1'b0, "mask_idle");
    rd(2'd2, 32'd0, 1'b0, "mask_load");
    rd(2'd2, 32'd2, 1'b0, "mask_cnt");
    rd(2'd2, 32'd1, 1'b0, "mask_cnt");
    rd(2'd2, 32'd0, 1'b0, "mask_int");
    rd(2'd0, 32'd0, 1'b0, "mask_ctrl_after");

    // CTRL write clears the pending flag; CPU write beats the one-shot EN clear
    wr(2'd0, 32'h9);
    rd(2'd0, 32'h9, 1'b0, "ww_flag_cleared");
    rd(2'd2, 32'd0, 1'b0, "ww_load");
    rd(2'd2, 32'd2, 1'b0, "ww_cnt");
    rd(2'd2, 32'd1, 1'b0, "ww_cnt");
    step(1'b1, 2'd0, 32'h9, 1'b1, 32'h9, 1'b1, "ww_write_at_int");
    rd(2'd0, 32'h9, 1'b0, "ww_cpu_wins");
    rd(2'd2, 32'd0, 1'b0, "ww_reload");
    rd(2'd2, 32'd2, 1'b0, "ww_rerun");
    rd(2'd2, 32'd1, 1'b0, "ww_rerun");
    rd(2'd2, 32'd0, 1'b1, "ww_int");
    rd(2'd0, 32'h8, 1'b1, "ww_oneshot_done");
    wr(2'd0, 32'd0);

    // Stop mid-count, freeze at 7
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    idle();
    idle();
    rd(2'd2, 32'd10, 1'b0, "stop_cnt");
    rd(2'd2, 32'd9,  1'b0, "stop_cnt");
    step(1'b1, 2'd0, 32'd0, 1'b1, 32'h1, 1'b0, "stop_write");
    rd(2'd2, 32'd7, 1'b0, "stop_count");
    rd(2'd2, 32'd7, 1'b0, "stop_frozen");
    rd(2'd0, 32'd0, 1'b0, "stop_ctrl");
    rd(2'd2, 32'd7, 1'b0, "stop_frozen");

    // Re-enable reloads from PRESET
    wr(2'd0, 32'h1);
    rd(2'd2, 32'd7,  1'b0, "reen_idle");
    rd(2'd2, 32'd7,  1'b0, "reen_load");
    rd(2'd2, 32'd10, 1'b0, "reen_reload");
    wr(2'd0, 32'd0);
    idle();
    rd(2'd2, 32'd8, 1'b0, "reen_stopped");

    // addr 3 ignores writes
    wr(2'd3, 32'hDEAD_BEEF);
    rd(2'd3, 32'd0,  1'b0, "a3_read");
    rd(2'd0, 32'd0,  1'b0, "a3_ctrl");
    rd(2'd1, 32'd10, 1'b0, "a3_preset");

    // PRESET=0 behaves as 1
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    idle();
    rd(2'd2, 32'd8, 1'b0, "p0_load");
    rd(2'd2, 32'd0, 1'b0, "p0_cnt");
    rd(2'd2, 32'd0, 1'b1, "p0_int");
    rd(2'd0, 32'h8, 1'b1, "p0_done");
    wr(2'd0, 32'd0);
    rd(2'd0, 32'd0, 1'b0, "p0_cleared");

    // COUNT write during CNT
    wr(2'd1, 32'd12);
    wr(2'd0, 32'h9);
    idle();
    idle();
    rd(2'd2, 32'd12, 1'b0, "cw_cnt");
    rd(2'd2, 32'd11, 1'b0, "cw_cnt");
    step(1'b1, 2'd2, 32'd2, 1'b1, 32'd10, 1'b0, "cw_write");
`ifdef TIMER_COUNT_WR_EN
    rd(2'd2, 32'd2, 1'b0, "cw_written");
    rd(2'd2, 32'd1, 1'b0, "cw_dec");
    rd(2'd2, 32'd0, 1'b1, "cw_int");
`else
    rd(2'd2, 32'd9, 1'b0, "cw_ignored");
    rd(2'd2, 32'd8, 1'b0, "cw_dec");
    rd(2'd2, 32'd7, 1'b0, "cw_dec");
`endif
    wr(2'd0, 32'd0);
    idle();
    idle();
    rd(2'd0, 32'd0, 1'b0, "cw_end");

    chk = 1'b0;
    idle();
    idle();
    if (exp_dout_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_dout_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
